row_scanner: RTL and testbench

ROW_SCANNER -- requirements
Module: row_scanner

---
 rtl/row_scanner_pkg.sv | 15 +
 rtl/row_scanner_cycle_timer.sv | 23 ++
 rtl/row_scanner.sv | 90 +++++++++
 tb/tb_row_scanner.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/row_scanner_pkg.sv
// scanner_pkg: shared state encoding and width helpers for the row scanner.
//   scan_state_t : scan FSM states
//   row_w()      : row index width for a given row count ($clog2 based)
//   cnt_w()      : dwell/blank counter width covering max(DWELL,BLANK) cycles
package scanner_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHOW, S_BLANK} scan_state_t;
  function automatic int row_w(input int rows);
    return rows > 1 ? $clog2(rows) : 1;
  endfunction
  function automatic int cnt_w(input int dwell, input int blank);
    int m;
    m = dwell > blank ? dwell : blank;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/row_scanner_cycle_timer.sv
// cycle_timer: loadable down-counter that saturates at zero, with a done flag.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero
//   load/value : load value (counter then runs value+1 cycles until done)
//   done       : high while the count is zero
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/row_scanner.sv
// row_scanner: multiplexed display row scanner (fetch row, show, blank, next).
//   clk, rst_n        : clock, async active-low reset
//   ena               : scan enable; low returns to idle with all outputs cleared
//   rd_req, rd_row    : row-data request and row index to the frame buffer
//   rd_valid, rd_data : frame buffer response, accepted only while fetching
//   row_sel, row_ena  : registered row decoder select and enable
//   cols              : latched column pattern for the lit row
//   frame_done        : one-cycle pulse when the last row wraps to row 0
module row_scanner import scanner_pkg::*; #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 4,
  parameter int BLANK = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  output logic                   rd_req,
  output logic [row_w(ROWS)-1:0] rd_row,
  input  logic                   rd_valid,
  input  logic [COLS-1:0]        rd_data,
  output logic [row_w(ROWS)-1:0] row_sel,
  output logic                   row_ena,
  output logic [COLS-1:0]        cols,
  output logic                   frame_done
);
  localparam int ROW_W = row_w(ROWS);
  localparam int CW    = cnt_w(DWELL, BLANK);
  scan_state_t   state;
  logic          t_load, t_done;
  logic [CW-1:0] t_value;
  // Timer is loaded on entry to SHOW and to BLANK; it idles at zero elsewhere.
  assign t_load  = ena && ((state == S_FETCH && rd_valid) || (state == S_SHOW && t_done));
  assign t_value = state == S_FETCH ? CW'(DWELL - 1) : CW'(BLANK - 1);
  cycle_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!ena),
    .load  (t_load),
    .value (t_value),
    .done  (t_done)
  );
  // rd_row is gated from registers only, so no input reaches it combinationally.
  assign rd_row = rd_req ? row_sel : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_req     <= 1'b0;
      row_sel    <= '0;
      row_ena    <= 1'b0;
      cols       <= '0;
      frame_done <= 1'b0;
    end else if (!ena) begin
      state      <= S_IDLE;
      rd_req     <= 1'b0;
      row_sel    <= '0;
      row_ena    <= 1'b0;
      cols       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          state  <= S_FETCH;
          rd_req <= 1'b1;
        end
        S_FETCH:
          if (rd_valid) begin
            cols    <= rd_data;
            rd_req  <= 1'b0;
            row_ena <= 1'b1;
            state   <= S_SHOW;
          end
        S_SHOW:
          if (t_done) begin
            row_ena <= 1'b0;
            state   <= S_BLANK;
          end
        S_BLANK:
          if (t_done) begin
            // ROWS is a power of two, so the natural wrap is modulo ROWS.
            row_sel    <= row_sel + 1'b1;
            frame_done <= row_sel == ROW_W'(ROWS - 1);
            rd_req     <= 1'b1;
            state      <= S_FETCH;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_row_scanner.sv
// tb_row_scanner: directed self-checking bench for row_scanner (8 rows, DWELL 4, BLANK 2).
module tb_row_scanner;
  logic       clk = 1'b0;
  logic       rst_n, ena, rd_valid;
  logic [7:0] rd_data;
  logic       rd_req, row_ena, frame_done;
  logic [2:0] rd_row, row_sel, prev_sel;
  logic [7:0] cols;
  int         tests = 0;
  int         fails = 0;
  int         pulses = 0;
  row_scanner #(.ROWS(8), .COLS(8), .DWELL(4), .BLANK(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rd_req     (rd_req),
    .rd_row     (rd_row),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .row_sel    (row_sel),
    .row_ena    (row_ena),
    .cols       (cols),
    .frame_done (frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [7:0] dec3to8(input logic [2:0] s, input logic e);
    logic [7:0] one;
    one = 8'd1;
    return e ? one << s : 8'd0;
  endfunction
  // Continuous checks: row_sel never moves while lit, decoder one-hot only while lit,
  // and a row is never lit while its data is being requested.
  always @(negedge clk) begin
    if (rst_n) begin
      if (row_sel != prev_sel) chk("sel_change_while_lit", row_ena, 0);
      chk("decoder_onehot", $onehot(dec3to8(row_sel, row_ena)), row_ena);
      if (rd_req) chk("req_while_lit", row_ena, 0);
    end
    prev_sel = row_sel;
  end
  initial begin
    int p, r;
    rst_n = 1'b0; ena = 1'b1; rd_valid = 1'b1; rd_data = 8'h3C;
    prev_sel = '0;
    repeat (2) @(negedge clk);
    chk("rst_row_ena", row_ena, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_row_sel", row_sel, 0);
    chk("rst_cols", cols, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_rd_row", rd_row, 0);
    rst_n = 1'b1;
    chk("c0_rd_req", rd_req, 0);
    // Free-running scan: row period 7, frame 56; run into SHOW of row 3 of frame 2.
    for (int k = 1; k <= 80; k++) begin
      step();
      p = (k - 1) % 7;
      r = ((k - 1) / 7) % 8;
      chk($sformatf("k%0d_row_sel", k), row_sel, r);
      chk($sformatf("k%0d_row_ena", k), row_ena, (p >= 1 && p <= 4));
      chk($sformatf("k%0d_rd_req", k), rd_req, p == 0);
      chk($sformatf("k%0d_rd_row", k), rd_row, p == 0 ? r : 0);
      chk($sformatf("k%0d_frame_done", k), frame_done, k == 57);
      if (frame_done) pulses++;
      if (p >= 1) chk($sformatf("k%0d_cols", k), cols, 8'h3C);
    end
    chk("frame_pulses", pulses, 1);
    // Drop ena in SHOW of row 3.
    ena = 1'b0;
    step();
    chk("off_row_ena", row_ena, 0);
    chk("off_row_sel", row_sel, 0);
    chk("off_rd_req", rd_req, 0);
    chk("off_cols", cols, 0);
    step();
    chk("off2_rd_req", rd_req, 0);
    ena = 1'b1;
    step();
    chk("restart_rd_req", rd_req, 1);
    chk("restart_rd_row", rd_row, 0);
    step();
    chk("restart_row_ena", row_ena, 1);
    chk("restart_row_sel", row_sel, 0);
    chk("restart_cols", cols, 8'h3C);
    // rd_valid pulses in SHOW and BLANK must not disturb cols.
    rd_valid = 1'b1; rd_data = 8'hFF;
    step();
    chk("show_valid_cols", cols, 8'h3C);
    chk("show_valid_ena", row_ena, 1);
    rd_valid = 1'b0;
    repeat (3) step();
    chk("blank0_ena", row_ena, 0);
    rd_valid = 1'b1; rd_data = 8'hEE;
    step();
    chk("blank_valid_cols", cols, 8'h3C);
    chk("blank1_ena", row_ena, 0);
    rd_valid = 1'b0; rd_data = 8'h00;
    step();
    // Row 1 fetch with rd_valid delayed five cycles.
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("wait%0d_rd_req", i), rd_req, 1);
      chk($sformatf("wait%0d_row_ena", i), row_ena, 0);
      chk($sformatf("wait%0d_rd_row", i), rd_row, 1);
      rd_valid = i == 6;
      rd_data = i == 6 ? 8'hA5 : 8'h10 + 8'(i);
      step();
    end
    rd_valid = 1'b0; rd_data = 8'h00;
    chk("late_cols", cols, 8'hA5);
    chk("late_row_ena", row_ena, 1);
    chk("late_rd_req", rd_req, 0);
    chk("late_row_sel", row_sel, 1);
    // Asynchronous reset in the middle of SHOW.
    step();
    chk("pre_rst_row_ena", row_ena, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_row_ena", row_ena, 0);
    chk("async_row_sel", row_sel, 0);
    chk("async_cols", cols, 0);
    chk("async_rd_req", rd_req, 0);
    @(negedge clk);
    chk("held_row_ena", row_ena, 0);
    rd_valid = 1'b1; rd_data = 8'h5A;
    rst_n = 1'b1;
    step();
    chk("post_rst_rd_req", rd_req, 1);
    chk("post_rst_rd_row", rd_row, 0);
    step();
    chk("post_rst_row_ena", row_ena, 1);
    chk("post_rst_row_sel", row_sel, 0);
    chk("post_rst_cols", cols, 8'h5A);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
